// File: rtl/fp_pkg.sv
// Shared constants and special-value encoders for the FP multiplier output finaliser.
// The FP_EXC_FLAGS_EN macro (consumed in fp_special_out) enables the sticky exception flags.
package fp_pkg;

  localparam int unsigned EXP_W_DEF = 8;
  localparam int unsigned MAN_W_DEF = 23;

  // Encoders build words at this width; callers truncate to their own word size.
  localparam int unsigned MAX_W = 128;

  localparam int unsigned FLG_W  = 3;
  localparam int unsigned FLG_NV = 2;
  localparam int unsigned FLG_OF = 1;
  localparam int unsigned FLG_UF = 0;

  typedef logic [MAX_W-1:0] fp_word_t;

  function automatic fp_word_t fp_exp_ones(input int unsigned exp_w, input int unsigned man_w);
    return ((MAX_W'(1) << exp_w) - MAX_W'(1)) << man_w;
  endfunction

  function automatic fp_word_t fp_qnan(input int unsigned exp_w, input int unsigned man_w);
    return fp_exp_ones(exp_w, man_w) | (MAX_W'(1) << (man_w - 1));
  endfunction

  function automatic fp_word_t fp_inf(input logic sign, input int unsigned exp_w,
                                      input int unsigned man_w);
    return (MAX_W'(sign) << (exp_w + man_w)) | fp_exp_ones(exp_w, man_w);
  endfunction

  function automatic fp_word_t fp_zero(input logic sign, input int unsigned exp_w,
                                       input int unsigned man_w);
    return MAX_W'(sign) << (exp_w + man_w);
  endfunction

endpackage

// File: rtl/fp_skid_buf.sv
// Generic W-bit two-entry valid/ready skid buffer; in_ready depends only on local state.
module fp_skid_buf #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_main, r_skid;
  logic         r_main_v, r_skid_v, r_in_ready;
  logic [W-1:0] w_main_n, w_skid_n;
  logic         w_main_v_n, w_skid_v_n;
  logic         w_acc, w_drain;

  assign w_acc   = i_valid & r_in_ready;
  assign w_drain = r_main_v & i_ready;

  // Main feeds the output; skid only fills while main is stalled.
  always_comb begin
    w_main_n   = r_main;
    w_main_v_n = r_main_v;
    w_skid_n   = r_skid;
    w_skid_v_n = r_skid_v;
    if (!r_main_v) begin
      if (w_acc) begin
        w_main_n   = i_data;
        w_main_v_n = 1'b1;
      end
    end else if (w_drain) begin
      if (r_skid_v) begin
        w_main_n   = r_skid;
        w_skid_v_n = 1'b0;
      end else if (w_acc) begin
        w_main_n = i_data;
      end else begin
        w_main_v_n = 1'b0;
      end
    end else if (w_acc) begin
      w_skid_n   = i_data;
      w_skid_v_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_main     <= w_main_n;
      r_skid     <= w_skid_n;
      r_main_v   <= w_main_v_n;
      r_skid_v   <= w_skid_v_n;
      r_in_ready <= ~w_skid_v_n;
    end
  end

  assign o_ready = r_in_ready;
  assign o_valid = r_main_v;
  assign o_data  = r_main;

endmodule

// File: rtl/fp_special_out.sv
// Exception finaliser: forces qNaN / signed Inf / signed zero, then buffers through a skid stage.
// Define FP_EXC_FLAGS_EN to build the sticky {NV, OF, UF} flag register and flag_clr logic.
module fp_special_out
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   nan,
  input  logic                   inf,
  input  logic                   zer,
  input  logic                   ovf,
  input  logic                   unf,
  input  logic [EXP_W+MAN_W:0]   Z,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   fp_Z,
  input  logic                   flag_clr,
  output logic [FLG_W-1:0]       flags
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic [W-1:0] w_sel;

  // First match wins: NaN, then Inf/overflow, then zero/underflow (flush-to-zero).
  always_comb begin
    w_sel = Z;
    if (nan) begin
      w_sel = W'(fp_qnan(EXP_W, MAN_W));
    end else if (inf || ovf) begin
      w_sel = W'(fp_inf(Z[W-1], EXP_W, MAN_W));
    end else if (zer || unf) begin
      w_sel = W'(fp_zero(Z[W-1], EXP_W, MAN_W));
    end
  end

  fp_skid_buf #(
    .W (W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_sel),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (fp_Z)
  );

`ifdef FP_EXC_FLAGS_EN
  logic             w_acc;
  logic [FLG_W-1:0] w_set;
  logic [FLG_W-1:0] r_flags;

  assign w_acc = in_valid & in_ready;

  always_comb begin
    w_set         = '0;
    w_set[FLG_NV] = w_acc & nan;
    w_set[FLG_OF] = w_acc & ovf & ~nan;
    w_set[FLG_UF] = w_acc & unf & ~nan & ~inf & ~ovf;
  end

  // A same-cycle set beats the clear for that bit only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (flag_clr) begin
      r_flags <= w_set;
    end else begin
      r_flags <= r_flags | w_set;
    end
  end

  assign flags = r_flags;
`else
  logic w_unused_flag_clr;

  assign w_unused_flag_clr = flag_clr;
  assign flags             = '0;
`endif

endmodule

// File: tb/tb_fp_special_out.sv
// Scoreboard bench for fp_special_out: driver pushes expected words, a monitor pops on each output transfer.
module tb_fp_special_out;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        nan, inf, zer, ovf, unf;
  logic [31:0] Z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_Z;
  logic        flag_clr;
  logic [2:0]  flags;

  logic [31:0] q[$];
  int          n_checks;
  int          n_errors;
  logic [2:0]  exp_flags;

  fp_special_out dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .nan       (nan),
    .inf       (inf),
    .zer       (zer),
    .ovf       (ovf),
    .unf       (unf),
    .Z         (Z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_Z      (fp_Z),
    .flag_clr  (flag_clr),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Flags only exist when the feature is built in.
  function automatic logic [2:0] fl(input logic [2:0] v);
`ifdef FP_EXC_FLAGS_EN
    return v;
`else
    return 3'b000 & v;
`endif
  endfunction

  // Monitor: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", fp_Z, 32'hxxxxxxxx);
      end else begin
        chk("fp_Z", fp_Z, q.pop_front());
      end
    end
  end

  // f = {nan, inf, zer, ovf, unf}; returns after the accepting edge (+1).
  task automatic send(input logic [31:0] z, input logic [4:0] f, input logic [31:0] e);
    bit ok;
    in_valid = 1'b1;
    Z        = z;
    {nan, inf, zer, ovf, unf} = f;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    {nan, inf, zer, ovf, unf} = 5'b0;
  endtask

  task automatic drain_wait();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    {nan, inf, zer, ovf, unf} = 5'b0;
    Z         = 32'h0;
    out_ready = 1'b1;
    flag_clr  = 1'b0;
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_fp_Z", fp_Z, 32'h0);
    chk("rst_flags", {29'b0, flags}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pass-through with one-cycle latency
    send(32'h3f800000, 5'b00000, 32'h3f800000);
    chk("latency_valid", {31'b0, out_valid}, 32'd1);
    chk("latency_data", fp_Z, 32'h3f800000);
    chk("flags_none", {29'b0, flags}, {29'b0, fl(3'b000)});

    // NaN has priority over Inf; then signed Inf
    send(32'hbf800000, 5'b11000, 32'h7fc00000);
    chk("flags_nv", {29'b0, flags}, {29'b0, fl(3'b100)});
    send(32'h80000123, 5'b01000, 32'hff800000);
    drain_wait();

    // Clear, then underflow flush and overflow saturation
    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    chk("flags_clr", {29'b0, flags}, 32'd0);
    send(32'h00000123, 5'b00001, 32'h00000000);
    send(32'hc1234567, 5'b00010, 32'hff800000);
    chk("flags_of_uf", {29'b0, flags}, {29'b0, fl(3'b011)});
    drain_wait();

    // Clear coincident with a NaN transfer: NV set wins, others clear
    flag_clr = 1'b1;
    send(32'h12345678, 5'b10000, 32'h7fc00000);
    flag_clr = 1'b0;
    chk("flags_clr_set", {29'b0, flags}, {29'b0, fl(3'b100)});
    exp_flags = fl(3'b100);
    drain_wait();

    // Backpressure: two words held, then four words in order
    out_ready = 1'b0;
    send(32'h40000000, 5'b00000, 32'h40000000);
    send(32'h40400000, 5'b00000, 32'h40400000);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_hold_data", fp_Z, 32'h40000000);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stable_data", fp_Z, 32'h40000000);
    chk("bp_stable_valid", {31'b0, out_valid}, 32'd1);
    fork
      begin
        send(32'h40800000, 5'b00000, 32'h40800000);
        send(32'hc0a00000, 5'b00100, 32'h80000000);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain_wait();
    chk("flags_after_bp", {29'b0, flags}, {29'b0, exp_flags});

    // Reset with two words buffered discards them
    out_ready = 1'b0;
    send(32'h11111111, 5'b00000, 32'h11111111);
    send(32'h22222222, 5'b00000, 32'h22222222);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_flags", {29'b0, flags}, 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", {31'b0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
